// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

    // FSM encoding of the fetch unit; HALT is only reachable when the
    // misaligned-redirect exception feature is built in.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    // One buffered fetch result at the default 32-bit PC width.
    typedef struct packed {
        logic [31:0]     pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_q_if.sv
// Bus bundle of the fetch unit: instruction-memory req/gnt/rvalid channel
// plus the valid/ready fetch channel towards decode.
// Optional macro IFU_MISALIGN_EXC_EN adds the fetch_misalign_o flag.
interface ifu_fetch_q_if
    import ifu_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [ILEN-1:0] imem_rdata_i;
    logic            fetch_valid_o;
    logic [XLEN-1:0] fetch_pc_o;
    logic [ILEN-1:0] fetch_instr_o;
    logic            fetch_ready_i;
`ifdef IFU_MISALIGN_EXC_EN
    logic            fetch_misalign_o;
`endif

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i,
        output fetch_valid_o,
        output fetch_pc_o,
        output fetch_instr_o,
        input  fetch_ready_i
`ifdef IFU_MISALIGN_EXC_EN
        ,
        output fetch_misalign_o
`endif
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i,
        input  fetch_valid_o,
        input  fetch_pc_o,
        input  fetch_instr_o,
        output fetch_ready_i
`ifdef IFU_MISALIGN_EXC_EN
        ,
        input  fetch_misalign_o
`endif
    );

endinterface

// File: rtl/ifu_sync_fifo.sv
// Synchronous FIFO with registered storage, occupancy count, flush, and
// push+pop in the same cycle at any occupancy (including full).
// DEPTH must be a power of two so the pointers wrap naturally.
module ifu_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;

    // Pointer and occupancy bookkeeping; flush empties the queue at once.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents are don't-care until marked valid by count.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];
    assign valid     = (count_q != '0);
    assign count     = count_q;

endmodule

// File: rtl/ifu_fetch_q.sv
// Decoupled instruction fetch unit: owns the PC, issues in-order imem
// requests under a credit limit, buffers responses with their PCs and
// hands them to decode. A redirect flushes the buffer and discards the
// responses that are still in flight.
// Optional macro IFU_MISALIGN_EXC_EN: a misaligned redirect target halts
// fetch and raises fetch_misalign_o until the next aligned redirect.
module ifu_fetch_q
    import ifu_pkg::*;
#(
    parameter int              XLEN            = 32,
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    ifu_fetch_q_if.master   bus
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int OW = $clog2(MAX_OUTSTANDING+1);
    localparam int EW = XLEN + ILEN;

    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_FLUSH = FLUSH;
`ifdef IFU_MISALIGN_EXC_EN
    localparam logic [1:0] ST_HALT  = HALT;
`endif

    function automatic logic [XLEN-1:0] next_word(input logic [XLEN-1:0] a);
        return a + XLEN'(4);
    endfunction

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] resp_pc_q;
    logic [OW-1:0]   outstanding_q;
    logic [OW-1:0]   out_next;
    logic [OW-1:0]   drop_cnt_q;
    logic [1:0]      state_q;
    logic [1:0]      redirect_state;

    logic [CW-1:0]   fifo_count;
    logic            fifo_valid;
    logic [EW-1:0]   head_data;
    logic [EW-1:0]   push_data;

    logic            halted;
    logic            req;
    logic            req_fire;
    logic            drop;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] target_pc;

`ifdef IFU_MISALIGN_EXC_EN
    logic            target_misaligned;
    assign target_pc         = redirect_pc_i;
    assign target_misaligned = (redirect_pc_i[1:0] != 2'b00);
    assign halted            = (state_q == ST_HALT);
`else
    logic            unused_low_bits;
    assign target_pc       = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign unused_low_bits = ^redirect_pc_i[1:0];
    assign halted          = 1'b0;
`endif

    // A request needs a free outstanding slot and a FIFO credit covering
    // every word already buffered or still on its way back.
    assign req = !rst_i && !redirect_i && !halted
              && (int'(outstanding_q) < MAX_OUTSTANDING)
              && ((int'(fifo_count) + int'(outstanding_q)) < DEPTH);
    assign req_fire = req && bus.imem_gnt_i;

    // Responses are stale when a flush is pending or one starts this cycle.
    assign drop = bus.imem_rvalid_i && (redirect_i || (drop_cnt_q != '0));
    assign push = bus.imem_rvalid_i && !drop;
    assign pop  = fifo_valid && bus.fetch_ready_i && !redirect_i;

    assign push_data = {resp_pc_q, bus.imem_rdata_i};

    // In-flight count after this cycle's grant and response.
    always_comb begin
        out_next = outstanding_q;
        if (req_fire)          out_next = out_next + OW'(1);
        if (bus.imem_rvalid_i) out_next = out_next - OW'(1);
    end

    // State entered on a redirect: drain stale responses first if any.
    always_comb begin
        redirect_state = (out_next != '0) ? ST_FLUSH : ST_RUN;
`ifdef IFU_MISALIGN_EXC_EN
        if (target_misaligned) redirect_state = ST_HALT;
`endif
    end

    // PC, response-PC, credit counters and the RUN/FLUSH/HALT state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            state_q       <= ST_RUN;
        end else begin
            outstanding_q <= out_next;
            if (redirect_i) begin
                pc_q       <= target_pc;
                resp_pc_q  <= target_pc;
                drop_cnt_q <= out_next;
                state_q    <= redirect_state;
            end else begin
                if (req_fire) pc_q      <= next_word(pc_q);
                if (push)     resp_pc_q <= next_word(resp_pc_q);
                if (drop)     drop_cnt_q <= drop_cnt_q - OW'(1);
                if ((state_q == ST_FLUSH) && drop && (drop_cnt_q == OW'(1)))
                    state_q <= ST_RUN;
            end
        end
    end

    ifu_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .flush     (redirect_i),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    assign bus.imem_req_o    = req;
    assign bus.imem_addr_o   = pc_q;
    assign bus.fetch_valid_o = fifo_valid;
    assign bus.fetch_pc_o    = halted ? pc_q : head_data[EW-1:ILEN];
    assign bus.fetch_instr_o = fifo_valid ? head_data[ILEN-1:0] : INSTR_NOP;
`ifdef IFU_MISALIGN_EXC_EN
    assign bus.fetch_misalign_o = halted;
`endif

endmodule

// File: doc/ifu_fetch_q.md
Name: ifu_fetch_q

Overview:
Parametrised, decoupled successor to the single-cycle PC unit. It owns the PC and issues in-order requests to instruction memory over a req/gnt + rvalid interface. It buffers returned words with their PCs in a small FIFO and presents them to decode on a valid/ready handshake. Branch/jump resolution lives downstream: any control transfer arrives as a single redirect, which flushes the buffer and discards stale in-flight responses.

Parameters:
XLEN, 32, address/PC width
DEPTH, 4, fetch FIFO entries (power of 2, >=2); also total credit (buffered + in-flight)
MAX_OUTSTANDING, 2, max accepted-but-unanswered imem requests (1..DEPTH)
RESET_PC, 32'h0000_0000, PC after reset

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous reset, active-high
redirect_i  in  1  control-transfer pulse from execute
redirect_pc_i  in  XLEN  redirect target
imem_req_o  out  1  request valid
imem_addr_o  out  XLEN  request address (word aligned)
imem_gnt_i  in  1  request accepted this cycle when imem_req_o=1
imem_rvalid_i  in  1  response valid; responses in order, >=1 cycle after gnt
imem_rdata_i  in  32  instruction word
fetch_valid_o  out  1  FIFO head valid
fetch_pc_o  out  XLEN  PC of head
fetch_instr_o  out  32  instruction of head
fetch_ready_i  in  1  decode consumes head when valid&ready

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous, active-high.
- Reset values:
  - Internal state: pc_q=RESET_PC, resp_pc_q=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, state=RUN.
  - Outputs: imem_req_o=0, fetch_valid_o=0, imem_addr_o=RESET_PC.
- Reset mid-transaction: all counters are cleared. Responses still arriving after reset are not tracked; the memory must also be reset.
- Request rule: imem_req_o = !redirect_i && state!=HALT && outstanding<MAX_OUTSTANDING && (count+outstanding)<DEPTH.
  - imem_addr_o = pc_q.
  - Once raised, req and addr stay stable until gnt. Withdrawal happens only on redirect.
  - On req&gnt: pc_q += 4 (XLEN wrap-around is modulo 2^XLEN, no flag) and outstanding++.
- Response rule: each imem_rvalid_i decrements outstanding.
  - If drop_cnt>0, the response is discarded and drop_cnt-- (state FLUSH).
  - Otherwise {resp_pc_q, imem_rdata_i} is pushed and resp_pc_q += 4.
  - Credit accounting guarantees a push never hits a full FIFO.
- FIFO: registered storage. fetch_* reflect the head. Push and pop in the same cycle are allowed at any occupancy, including full.
  - Latency: gnt in cycle N, rvalid in N+L, fetch_valid_o high in N+L+1.
- Redirect (highest priority, cycle R):
  - pc_q and resp_pc_q are set to the target; the FIFO is flushed.
  - A pop by decode in cycle R is void; decode flushes itself.
  - drop_cnt <= outstanding - imem_rvalid_i, so a response arriving in cycle R is also dropped.
  - State goes to FLUSH if drop_cnt_next>0, else RUN.
  - First request to the target is at R+1. fetch_valid_o=0 at R+1.
- States:
  - RUN: normal operation.
  - FLUSH: drop_cnt>0; requests are still issued to new addresses; goes to RUN when drop_cnt reaches 0.
  - HALT: exists only with the optional feature.
- Back-to-back redirects: the second overrides the first; drop_cnt is recomputed from outstanding.
- Without the optional feature, redirect_pc_i[1:0] is forced to 0.

Optional Feature:
IFU_MISALIGN_EXC_EN
- Defined: adds output fetch_misalign_o (1 bit, reset 0).
  - A redirect with redirect_pc_i[1:0]!=0 performs the normal flush, then enters HALT.
  - HALT: no requests, fetch_misalign_o=1, fetch_pc_o=faulting target.
  - HALT exits only on the next aligned redirect or on reset.
- Undefined: no port; low bits are silently cleared; HALT state is absent.

Decomposition:
- Package ifu_pkg:
  - ILEN=32 and INSTR_NOP=32'h0000_0013.
  - fetch_entry_t {pc, instr}.
  - fetch_state_e {RUN, FLUSH, HALT}.
- One sub-module, ifu_sync_fifo (params WIDTH, DEPTH): count output, flush input, simultaneous push/pop.

Test Plan:
1. RESET_PC=0x80, gnt=1, latency 1, ready=1 -> addresses 0x80, 0x84, 0x88…; fetch_pc_o 0x80 with the matching instr, 3 cycles after reset release, then one per cycle.
2. ready=0 for 20 cycles -> exactly 4 requests accepted, imem_req_o low afterwards, fetch_pc_o held at first PC; ready=1 -> in-order drain with no gaps.
3. Latency 3, 2 outstanding, redirect to 0x200 -> both stale responses dropped, never visible; next fetch_pc_o=0x200, then 0x204.
4. Redirect in the same cycle as rvalid with outstanding=1 -> drop_cnt=0, state RUN, that response discarded, first request 0x300 at R+1.
5. gnt withheld 3 cycles -> imem_addr_o stable, pc_q unchanged; single increment on gnt.
6. With IFU_MISALIGN_EXC_EN, redirect to 0x102 -> fetch_misalign_o=1, no requests; redirect to 0x100 -> fetch resumes at 0x100, flag cleared.
